// File: rtl/axi4_lite_regfile.sv
// Parametrised AXI4-Lite slave register file with read-only status registers,
// byte strobes, decoupled AW/W acceptance, write-commit pulses and SLVERR.
module axi4_lite_regfile #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_NUM_REGS         = 16,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
   parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
   input  logic                                     ACLK,
   input  logic                                     ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
   input  logic [2:0]                               S_AXI_AWPROT,
   input  logic                                     S_AXI_AWVALID,
   output logic                                     S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
   input  logic                                     S_AXI_WVALID,
   output logic                                     S_AXI_WREADY,
   output logic [1:0]                               S_AXI_BRESP,
   output logic                                     S_AXI_BVALID,
   input  logic                                     S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
   input  logic [2:0]                               S_AXI_ARPROT,
   input  logic                                     S_AXI_ARVALID,
   output logic                                     S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
   output logic [1:0]                               S_AXI_RRESP,
   output logic                                     S_AXI_RVALID,
   input  logic                                     S_AXI_RREADY,
   output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
   input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
   output logic [C_NUM_REGS-1:0]                    wr_pulse
);

   localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned NR    = C_NUM_REGS;
   localparam int unsigned OFF_W = $clog2(SW);
   localparam int unsigned IDX_W = $clog2(NR);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_AW_HELD, W_W_HELD, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] a);
      return IDX_W'(a >> OFF_W);
   endfunction

   function automatic logic addr_in_range(input logic [AW-1:0] a);
      return (a >> (IDX_W + OFF_W)) == '0;
   endfunction

   logic [DW-1:0]    regs [NR];
   wstate_t          wstate, wstate_n;
   rstate_t          rstate, rstate_n;
   logic [AW-1:0]    aw_buf;
   logic [DW-1:0]    w_buf;
   logic [SW-1:0]    wstrb_buf;
   logic             aw_hs, w_hs, ar_hs;
   logic             commit, commit_ok;
   logic [AW-1:0]    c_addr;
   logic [DW-1:0]    c_data;
   logic [SW-1:0]    c_strb;
   logic [IDX_W-1:0] c_idx, r_idx;
   logic [DW-1:0]    r_data;
   logic [1:0]       r_resp;
   logic             unused;

   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};
   assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;

   // Write path: commit fires when the second of AW/W lands, held or same-cycle
   always_comb begin
      wstate_n = wstate;
      commit   = 1'b0;
      c_addr   = aw_hs ? S_AXI_AWADDR : aw_buf;
      c_data   = w_hs ? S_AXI_WDATA : w_buf;
      c_strb   = w_hs ? S_AXI_WSTRB : wstrb_buf;
      case (wstate)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit   = 1'b1;
               wstate_n = W_RESP;
            end else if (aw_hs) begin
               wstate_n = W_AW_HELD;
            end else if (w_hs) begin
               wstate_n = W_W_HELD;
            end
         end
         W_AW_HELD: if (w_hs) begin
            commit   = 1'b1;
            wstate_n = W_RESP;
         end
         W_W_HELD: if (aw_hs) begin
            commit   = 1'b1;
            wstate_n = W_RESP;
         end
         W_RESP: if (S_AXI_BREADY) wstate_n = W_IDLE;
         default: wstate_n = W_IDLE;
      endcase
      c_idx     = addr_idx(c_addr);
      commit_ok = commit && addr_in_range(c_addr) && !C_RO_MASK[c_idx];
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wstate        <= W_IDLE;
         aw_buf        <= '0;
         w_buf         <= '0;
         wstrb_buf     <= '0;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
         wr_pulse      <= '0;
         for (int unsigned i = 0; i < NR; i++) regs[i] <= '0;
      end else begin
         wstate        <= wstate_n;
         S_AXI_AWREADY <= (wstate_n == W_IDLE) || (wstate_n == W_W_HELD);
         S_AXI_WREADY  <= (wstate_n == W_IDLE) || (wstate_n == W_AW_HELD);
         S_AXI_BVALID  <= (wstate_n == W_RESP);
         wr_pulse      <= commit_ok ? (NR'(1) << c_idx) : '0;
         if (aw_hs) aw_buf <= S_AXI_AWADDR;
         if (w_hs) begin
            w_buf     <= S_AXI_WDATA;
            wstrb_buf <= S_AXI_WSTRB;
         end
         if (commit) S_AXI_BRESP <= commit_ok ? RESP_OKAY : RESP_SLVERR;
         if (commit_ok) begin
            for (int unsigned b = 0; b < SW; b++)
               if (c_strb[b]) regs[c_idx][b*8 +: 8] <= c_data[b*8 +: 8];
         end
      end
   end

   // Read path: data captured at the AR handshake, before any same-cycle commit
   always_comb begin
      rstate_n = rstate;
      r_idx    = addr_idx(S_AXI_ARADDR);
      r_data   = '0;
      r_resp   = RESP_OKAY;
      case (rstate)
         R_IDLE:  if (ar_hs) rstate_n = R_DATA;
         R_DATA:  if (S_AXI_RREADY) rstate_n = R_IDLE;
         default: rstate_n = R_IDLE;
      endcase
      if (!addr_in_range(S_AXI_ARADDR)) r_resp = RESP_SLVERR;
      else if (C_RO_MASK[r_idx])        r_data = reg_in[DW*r_idx +: DW];
      else                              r_data = regs[r_idx];
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rstate        <= R_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= RESP_OKAY;
      end else begin
         rstate        <= rstate_n;
         S_AXI_ARREADY <= (rstate_n == R_IDLE);
         S_AXI_RVALID  <= (rstate_n == R_DATA);
         if (ar_hs) begin
            S_AXI_RDATA <= r_data;
            S_AXI_RRESP <= r_resp;
         end
      end
   end

   // Read-only registers are never written, so their slices stay zero
   for (genvar i = 0; i < NR; i++) begin : g_out
      assign reg_out[i*DW +: DW] = regs[i];
   end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Randomised bench for axi4_lite_regfile against an array-based register model
// with register 15 configured read-only.
module tb_axi4_lite_regfile;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 16;
   localparam int unsigned AW = 8;
   localparam logic [15:0] RO = 16'h8000;

   logic           clk = 1'b0;
   logic           ARESET;
   logic [AW-1:0]  AWADDR, ARADDR;
   logic           AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic           ARVALID, ARREADY, RVALID, RREADY;
   logic [DW-1:0]  WDATA, RDATA;
   logic [3:0]     WSTRB;
   logic [1:0]     BRESP, RRESP;
   logic [NR*DW-1:0] reg_out, reg_in;
   logic [NR-1:0]  wr_pulse;

   logic [31:0] m_regs [NR];
   logic [31:0] rin [NR];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = rin[i];
   end

   axi4_lite_regfile #(
      .C_S_AXI_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_S_AXI_ADDR_WIDTH(AW), .C_RO_MASK(RO)
   ) dut (
      .ACLK(clk), .ARESET(ARESET),
      .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
      .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
      .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
      .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
      .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
      .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] exp_reg_out();
      logic [511:0] r = '0;
      for (int i = 0; i < NR; i++) r[i*32 +: 32] = RO[i] ? 32'h0 : m_regs[i];
      return r;
   endfunction

   function automatic bit wr_ok(input logic [7:0] a);
      logic [3:0] idx = a[5:2];
      return (a[7:6] == 2'b00) && !RO[idx];
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [7:0] a);
      logic [3:0] idx = a[5:2];
      if (a[7:6] != 2'b00) return 32'h0;
      return RO[idx] ? rin[idx] : m_regs[idx];
   endfunction

   task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [3:0] idx = a[5:2];
      if (wr_ok(a))
         for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int aw_dly, input int w_dly);
      bit aw_done = 0, w_done = 0, aw_f, w_f;
      logic [3:0] idx = a[5:2];
      logic [15:0] exp_pulse = wr_ok(a) ? (16'd1 << idx) : 16'd0;
      BREADY = 1'b1;
      for (int c = 0; c < 60 && !(aw_done && w_done); c++) begin
         AWADDR = a; WDATA = d; WSTRB = s;
         AWVALID = !aw_done && (c >= aw_dly);
         WVALID  = !w_done && (c >= w_dly);
         aw_f = AWVALID && AWREADY;
         w_f  = WVALID && WREADY;
         @(posedge clk); #1;
         if (aw_f) begin aw_done = 1; AWVALID = 1'b0; end
         if (w_f) begin w_done = 1; WVALID = 1'b0; end
         if (!(aw_done && w_done)) check("bvalid_early", BVALID, 0);
      end
      if (!(aw_done && w_done)) begin
         check("wr_timeout", 0, 1);
         return;
      end
      check("bvalid", BVALID, 1);
      check("bresp", BRESP, wr_ok(a) ? 2'b00 : 2'b10);
      check("wr_pulse", wr_pulse, exp_pulse);
      model_write(a, d, s);
      check("reg_out", reg_out, exp_reg_out());
      @(posedge clk); #1;
      check("bvalid_clr", BVALID, 0);
      check("wr_pulse_clr", wr_pulse, 0);
   endtask

   task automatic rd(input logic [7:0] a);
      bit done = 0, f;
      logic [31:0] ed = exp_rdata(a);
      logic [1:0]  er = (a[7:6] == 2'b00) ? 2'b00 : 2'b10;
      RREADY = 1'b1; ARADDR = a; ARVALID = 1'b1;
      for (int c = 0; c < 60 && !done; c++) begin
         f = ARVALID && ARREADY;
         @(posedge clk); #1;
         if (f) begin done = 1; ARVALID = 1'b0; end
      end
      if (!done) begin
         check("rd_timeout", 0, 1);
         return;
      end
      check("rvalid", RVALID, 1);
      check("rdata", RDATA, ed);
      check("rresp", RRESP, er);
      @(posedge clk); #1;
      check("rvalid_clr", RVALID, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] old, nv;
      logic [7:0]  a;
      ARESET = 1'b1; AWADDR = '0; ARADDR = '0; AWVALID = 0; WVALID = 0; ARVALID = 0;
      WDATA = '0; WSTRB = '0; BREADY = 0; RREADY = 0;
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; rin[i] = $urandom; end
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
      check("rst_valid", {BVALID, RVALID, BRESP, RRESP}, 6'b0);
      check("rst_regs", reg_out, 0);
      check("rst_misc", {RDATA, wr_pulse}, 0);
      ARESET = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

      for (int i = 0; i < 4; i++) wr(8'(i*4), 32'(i+1), 4'hF, 0, 0);
      for (int i = 0; i < 4; i++) rd(8'(i*4));

      wr(8'h10, 32'hA5A5_A5A5, 4'hF, 3, 0);
      wr(8'h14, 32'hFFFF_FFFF, 4'hF, 0, 0);
      wr(8'h14, 32'h0000_0012, 4'b0001, 0, 0);
      rd(8'h14);

      rin[15] = 32'hDEAD_BEEF;
      wr(8'h3C, 32'h1234_5678, 4'hF, 0, 1);
      rd(8'h3C);
      rd(8'h40);

      // Concurrent write+read of one register, then responses stalled
      old = m_regs[2]; nv = $urandom;
      BREADY = 0; RREADY = 0;
      AWADDR = 8'h08; WDATA = nv; WSTRB = 4'hF; ARADDR = 8'h08;
      AWVALID = 1; WVALID = 1; ARVALID = 1;
      @(posedge clk); #1;
      AWVALID = 0; WVALID = 0; ARVALID = 0;
      model_write(8'h08, nv, 4'hF);
      for (int c = 0; c < 10; c++) begin
         check("hold_valid", {BVALID, RVALID}, 2'b11);
         check("hold_resp", {BRESP, RRESP}, 4'b0);
         check("hold_rdata", RDATA, old);
         check("hold_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
         check("hold_pulse", wr_pulse, (c == 0) ? 16'h0004 : 16'h0000);
         @(posedge clk); #1;
      end
      BREADY = 1; RREADY = 1;
      @(posedge clk); #1;
      check("hold_release", {BVALID, RVALID}, 2'b00);
      check("hold_reg_out", reg_out, exp_reg_out());

      // Reset while a write response is pending
      BREADY = 0;
      AWADDR = 8'h00; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
      @(posedge clk); #1;
      AWVALID = 0; WVALID = 0;
      check("pre_rst_bvalid", BVALID, 1);
      ARESET = 1'b1;
      #1;
      check("mid_rst_bvalid", BVALID, 0);
      check("mid_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
      check("mid_rst_regs", reg_out, 0);
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      @(posedge clk); #1;
      ARESET = 1'b0; BREADY = 1;
      @(posedge clk); #1;
      check("mid_rst_release", {AWREADY, WREADY, ARREADY}, 3'b111);
      rd(8'h00);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 3) == 0) a = 8'($urandom);
         else a = 8'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) rin[$urandom_range(0, 15)] = $urandom;
         if ($urandom_range(0, 1) == 0)
            wr(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            rd(a);
      end
      check("final_reg_out", reg_out, exp_reg_out());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi4_lite_regfile.md
# axi4_lite_regfile

Parametrised AXI4-Lite slave register file, the next generation of the fixed four-register AXI4-Lite slave IP. It generalises data width and register count, adds per-register read-only status inputs, byte strobes, decoupled AW/W acceptance, write-commit pulses and SLVERR on illegal accesses. It sits behind the PS/VIP master on the AXI interconnect and exposes flattened control and status buses to fabric logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width, 32 or 64.
- C_NUM_REGS, 16: register count, power of two, 4..256.
- C_S_AXI_ADDR_WIDTH, 8: byte-address width, ≥ log2(C_NUM_REGS)+log2(C_S_AXI_DATA_WIDTH/8).
- C_RO_MASK, 16'h0000: bit i set means register i is read-only and reads reg_in slice i.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_W/3/1/1  write address channel; AWPROT ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DW/DW/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_W/3/1/1  read address; ARPROT ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DW/2/1/1  read data channel.
- reg_out  out  C_NUM_REGS*DW  flattened control registers, register i at [i*DW +: DW]; RO slices read 0.
- reg_in  in  C_NUM_REGS*DW  flattened status inputs, used only for RO registers.
- wr_pulse  out  C_NUM_REGS  one-cycle strobe on bit i when register i is written successfully.

## Operation
- Index = ADDR[log2(NUM_REGS)+log2(DW/8)-1 : log2(DW/8)]; low byte-offset bits ignored. Address bits above the index field nonzero → out of range.
- Write path: one-entry AW holding buffer and one-entry W holding buffer, filled independently. AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
- Commit when both buffers full (including same-cycle fill): writable in-range register updated byte-wise per WSTRB (WSTRB=0 → no change, still OKAY), wr_pulse[i]=1, BRESP=OKAY. RO target or out of range → no update, no pulse, BRESP=SLVERR (2'b10). Buffers cleared at commit.
- BVALID held with BRESP stable until BREADY; no new AW/W accepted while BVALID.
- Read path: ARREADY = !RVALID. On AR handshake, RDATA captured: writable register → current stored value; RO → reg_in slice sampled that cycle; out of range → 0 with RRESP=SLVERR; else OKAY. RVALID/RDATA/RRESP held until RREADY.
- Read and write paths fully independent; read of a register committing in the same cycle returns the pre-write value.
- States: write path IDLE → (AW_HELD | W_HELD) → RESP → IDLE; read path IDLE → RDATA → IDLE.

## Timing
- Reset (ARESET high, any time, including mid-transaction): all registers, reg_out, wr_pulse, BVALID, RVALID, BRESP, RRESP, RDATA = 0; AWREADY/WREADY/ARREADY = 0; pending buffers discarded. First cycle after deassertion: AWREADY, WREADY, ARREADY = 1.
- Write latency: BVALID and updated reg_out/wr_pulse one cycle after the later of the AW and W handshakes.
- Read latency: RVALID one cycle after AR handshake.
- Throughput with BREADY/RREADY tied high: one write per 2 cycles, one read per 2 cycles, concurrently.
- VALID without READY never dropped by slave; master-side VALID withdrawal before handshake not supported.

## Test plan
- Four sequential writes 0x1..0x4 to 0x00,0x04,0x08,0x0C, then read back → RDATA 0x1..0x4, all OKAY, wr_pulse bits 0..3 each pulse once.
- W first (0xA5A5A5A5) then AW 0x10 three cycles later → BVALID exactly one cycle after AW handshake, reg_out[4] = 0xA5A5A5A5.
- Write 0xFFFFFFFF to 0x14, then 0x00000012 with WSTRB=4'b0001 → read 0xFFFFFF12.
- C_RO_MASK=16'h8000, reg_in[15]=0xDEADBEEF: write 0x3C → BRESP SLVERR, no pulse; read 0x3C → 0xDEADBEEF OKAY. Read 0x40 (ADDR_W=8) → 0, SLVERR.
- BREADY and RREADY held low 10 cycles → BVALID/RVALID, BRESP/RDATA stable; AWREADY/WREADY/ARREADY low throughout.
- Assert ARESET during a pending BVALID after writing 0x55 to 0x00 → BVALID drops immediately, read of 0x00 after release → 0x0.
